mem_port_arb: RTL and testbench

//  Shares the single-ported SISC unified memory between instruction fetch (IF port, read-only)
//  and LOD/STR data access (D port, read/write). Requests are arbitrated round-robin, each access
//  is sequenced over a fixed memory latency, and the result is returned with a one-cycle ack.

---
 rtl/mem_port_arb_pkg.sv | 25 ++
 rtl/arb_lat_cnt.sv | 39 +++
 rtl/mem_port_arb.sv | 137 +++++++++++++
 tb/tb_mem_port_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states,
// requester IDs, latency default and counter sizing.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_port_e;

  localparam int unsigned MEM_LAT_DEF = 2;
  localparam int unsigned CNT_W       = 4;

  // Counter preload so that WAIT spans exactly `lat` cycles.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_lat_cnt.sv
// Memory-latency down-counter: load, decrement, saturates at zero.
module arb_lat_cnt
  import mem_port_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing the single-ported unified memory between
// instruction fetch (read-only) and LOD/STR data access.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    state_q, state_d;
  arb_port_e     gnt_q, gnt_d;
  arb_port_e     last_q, last_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             grant_if;
  logic             grant_d;

  // Round-robin: on a tie the port not served last wins.
  assign grant_if = if_req && (!d_req || (last_q == GNT_D));
  assign grant_d  = d_req && (!if_req || (last_q == GNT_IF));

  assign cnt_load = (state_q == ST_ISSUE);
  assign cnt_dec  = (state_q == ST_WAIT) && !cnt_zero;

  arb_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_f),
    .load     (cnt_load),
    .load_val (lat_load(MEM_LAT)),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  // State register plus access latches.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IF;
      last_q      <= GNT_D;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state sequencing IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (if_req || d_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_zero) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant capture, read-data capture and round-robin history update.
  always_comb begin
    gnt_d       = gnt_q;
    last_d      = last_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          gnt_d       = GNT_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end else if (grant_d) begin
          gnt_d       = GNT_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end
      end
      ST_WAIT: begin
        if (cnt_zero && !mem_we_q) rdata_d = mem_rdata;
      end
      ST_RESP: last_d = gnt_q;
      default: ;
    endcase
  end

  // Outputs decoded from state; write enable only qualifies the strobe cycle.
  always_comb begin
    busy   = (state_q != ST_IDLE);
    mem_en = (state_q == ST_ISSUE);
    mem_we = (state_q == ST_ISSUE) && mem_we_q;
    if_ack = (state_q == ST_RESP) && (gnt_q == GNT_IF);
    d_ack  = (state_q == ST_RESP) && (gnt_q == GNT_D);
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb (MEM_LAT 2, plus 1 and 15 latency builds).
module tb_mem_port_arb;

  logic        clk;
  logic        rst_f;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_ack, d_ack, busy, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rdata;

  logic        l1_req, l1_ack, l1_dack, l1_busy, l1_en, l1_we;
  logic [15:0] l1_maddr;
  logic [31:0] l1_mwdata, l1_rdata;
  logic        l15_req, l15_ack, l15_dack, l15_busy, l15_en, l15_we;
  logic [15:0] l15_maddr;
  logic [31:0] l15_mwdata, l15_rdata;

  int checks = 0;
  int errors = 0;
  int if_acks = 0;
  int d_acks = 0;
  int excl_viol = 0;
  logic [1:0] en_pipe;

  mem_port_arb #(.AW(16), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arb #(.AW(16), .DW(32), .MEM_LAT(1)) u_l1 (
    .clk(clk), .rst_f(rst_f),
    .if_req(l1_req), .if_addr(16'h0100), .if_ack(l1_ack),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(32'h0), .d_ack(l1_dack),
    .rdata(l1_rdata), .busy(l1_busy),
    .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_maddr), .mem_wdata(l1_mwdata),
    .mem_rdata(32'h1234_5678)
  );

  mem_port_arb #(.AW(16), .DW(32), .MEM_LAT(15)) u_l15 (
    .clk(clk), .rst_f(rst_f),
    .if_req(l15_req), .if_addr(16'h0200), .if_ack(l15_ack),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(32'h0), .d_ack(l15_dack),
    .rdata(l15_rdata), .busy(l15_busy),
    .mem_en(l15_en), .mem_we(l15_we), .mem_addr(l15_maddr), .mem_wdata(l15_mwdata),
    .mem_rdata(32'hCAFE_0015)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model for the MEM_LAT=2 instance: data valid only 2 cycles after mem_en.
  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) en_pipe <= 2'b00;
    else        en_pipe <= {en_pipe[0], mem_en};
  end
  always_comb begin
    mem_rdata = en_pipe[1] ? {16'h8001, 1'b0, mem_addr[15:1]} : 32'hBAD0_BAD0;
  end

  // Ack pulse counters and exclusivity monitor.
  always @(negedge clk) begin
    if (rst_f) begin
      if (if_ack) if_acks = if_acks + 1;
      if (d_ack)  d_acks  = d_acks + 1;
      if ((mem_en && (if_ack || d_ack)) || (if_ack && d_ack)) excl_viol = excl_viol + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int acks0;
    rst_f = 1'b0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; l1_req = 0; l15_req = 0;
    step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_f = 1'b1;
    step();

    // IF read at addr 0x0004
    if_req = 1; if_addr = 16'h0004;
    chk("if_idle_busy", {31'b0, busy}, 32'd0);
    step();
    chk("if_mem_en", {31'b0, mem_en}, 32'd1);
    chk("if_mem_we", {31'b0, mem_we}, 32'd0);
    chk("if_mem_addr", {16'b0, mem_addr}, 32'h0004);
    chk("if_early_ack", {31'b0, if_ack}, 32'd0);
    step();
    chk("if_en_once", {31'b0, mem_en}, 32'd0);
    step();
    chk("if_no_ack_t3", {31'b0, if_ack}, 32'd0);
    step();
    chk("if_ack", {31'b0, if_ack}, 32'd1);
    chk("if_dack_quiet", {31'b0, d_ack}, 32'd0);
    chk("if_rdata", rdata, 32'h8001_0002);
    if_req = 0;
    step();
    chk("if_ack_pulse", {31'b0, if_ack}, 32'd0);
    chk("if_idle", {31'b0, busy}, 32'd0);

    // D store
    d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("st_mem_en", {31'b0, mem_en}, 32'd1);
    chk("st_mem_we", {31'b0, mem_we}, 32'd1);
    chk("st_mem_addr", {16'b0, mem_addr}, 32'h0010);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("st_we_once", {31'b0, mem_we}, 32'd0);
    chk("st_addr_held", {16'b0, mem_addr}, 32'h0010);
    step();
    step();
    chk("st_dack", {31'b0, d_ack}, 32'd1);
    chk("st_ifack_quiet", {31'b0, if_ack}, 32'd0);
    chk("st_rdata_kept", rdata, 32'h8001_0002);
    d_req = 0; d_we = 0;
    step();

    // Contention after reset: IF, D, IF, D at 5-cycle spacing
    rst_f = 0; step(); rst_f = 1; step();
    if_req = 1; if_addr = 16'h0020; d_req = 1; d_we = 0; d_addr = 16'h0040;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr%0d_en", k), {31'b0, mem_en}, 32'd1);
      chk($sformatf("rr%0d_addr", k), {16'b0, mem_addr}, (k % 2 == 0) ? 32'h0020 : 32'h0040);
      step(); step(); step();
      chk($sformatf("rr%0d_ifack", k), {31'b0, if_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_dack", k), {31'b0, d_ack}, (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k == 3) begin
        if_req = 0; d_req = 0;
      end
      step();
    end
    chk("rr_final_rdata", rdata, 32'h8001_0020);

    // Request withdrawn after one cycle: load still completes once
    acks0 = d_acks;
    d_req = 1; d_we = 0; d_addr = 16'h0030;
    step();
    d_req = 0;
    chk("wd_mem_en", {31'b0, mem_en}, 32'd1);
    chk("wd_mem_addr", {16'b0, mem_addr}, 32'h0030);
    step(); step(); step();
    chk("wd_dack", {31'b0, d_ack}, 32'd1);
    chk("wd_rdata", rdata, 32'h8001_0018);
    for (int i = 0; i < 6; i++) step();
    chk("wd_one_ack", d_acks - acks0, 32'd1);

    // Reset asserted mid-WAIT abandons the access
    acks0 = if_acks;
    if_req = 1; if_addr = 16'h0050;
    step(); step();
    chk("mw_busy_before", {31'b0, busy}, 32'd1);
    rst_f = 0;
    #1;
    chk("mw_busy", {31'b0, busy}, 32'd0);
    chk("mw_rdata", rdata, 32'd0);
    chk("mw_mem_en", {31'b0, mem_en}, 32'd0);
    if_req = 0;
    step();
    rst_f = 1;
    for (int i = 0; i < 6; i++) step();
    chk("mw_no_stale_ack", if_acks - acks0, 32'd0);

    // Latency builds: ack MEM_LAT+2 cycles after sampled request
    l1_req = 1; n = 0;
    do begin step(); n++; end while (!l1_ack && n < 40);
    l1_req = 0;
    chk("lat1_cycles", n, 32'd3);
    chk("lat1_rdata", l1_rdata, 32'h1234_5678);
    step(); step();
    l15_req = 1; n = 0;
    do begin step(); n++; end while (!l15_ack && n < 40);
    l15_req = 0;
    chk("lat15_cycles", n, 32'd17);
    chk("lat15_rdata", l15_rdata, 32'hCAFE_0015);
    step(); step();

    chk("ack_en_exclusive", excl_viol, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
